// File: rtl/dmem_responder.sv
// Data-memory responder: captures one load/store request, waits LATENCY cycles,
// performs the word access, and then issues a one-cycle response strobe.

module dmem_byte_lane (
  input  logic [7:0] old_byte,
  input  logic [7:0] wr_byte,
  input  logic       we,
  output logic [7:0] new_byte
);
  assign new_byte = we ? wr_byte : old_byte;
endmodule

module dmem_responder #(
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] dmem_addr,
  input  logic [3:0]  dmem_rmask,
  input  logic [3:0]  dmem_wmask,
  input  logic [31:0] dmem_wdata,
  output logic [31:0] dmem_rdata,
  output logic        dmem_resp,
  output logic        busy,
  output logic [31:0] req_count
);
  localparam int DEPTH     = 1 << DEPTH_LOG2;
  localparam int NUM_LANES = 4;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  typedef struct packed {
    logic [DEPTH_LOG2-1:0]      idx;
    logic [NUM_LANES-1:0]       rmask;
    logic [NUM_LANES-1:0]       wmask;
    logic [NUM_LANES-1:0][7:0]  wdata;
  } req_t;

  state_t state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  req_t cap, acc, req_in;
  logic req_vld, enter_resp;
  logic [31:0] rdata_q;
  logic [NUM_LANES-1:0][7:0] mem [DEPTH];
  logic [NUM_LANES-1:0][7:0] old_word, new_word;

  assign req_in  = '{idx: dmem_addr[DEPTH_LOG2+1:2], rmask: dmem_rmask,
                     wmask: dmem_wmask, wdata: dmem_wdata};
  assign req_vld = |(dmem_rmask | dmem_wmask);

  // With zero wait states the access happens on the capture edge itself,
  // so the live inputs stand in for the not-yet-captured registers.
  always_comb begin
    acc = cap;
    if (state == IDLE) acc = req_in;
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: if (req_vld) begin
        cnt_nxt   = 4'(LATENCY);
        state_nxt = (LATENCY == 0) ? RESP : WAIT;
      end
      WAIT: begin
        cnt_nxt = cnt - 4'd1;
        if (cnt == 4'd1) state_nxt = RESP;
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign enter_resp = (state_nxt == RESP);
  assign old_word   = mem[acc.idx];

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    dmem_byte_lane u_lane (
      .old_byte(old_word[i]),
      .wr_byte (acc.wdata[i]),
      .we      (acc.wmask[i]),
      .new_byte(new_word[i])
    );
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      cap       <= '0;
      rdata_q   <= '0;
      req_count <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (state == IDLE && req_vld) cap <= req_in;
      // Loads (including combined load+store) return the pre-write word.
      if (enter_resp && |acc.rmask) rdata_q <= old_word;
      else                          rdata_q <= '0;
      if (state == RESP) req_count <= req_count + 32'd1;
    end
  end

  // Array is not reset; rst gating keeps a write from slipping in under reset.
  always_ff @(posedge clk) begin
    if (rst && enter_resp && |acc.wmask) mem[acc.idx] <= new_word;
  end

  assign dmem_rdata = rdata_q;
  assign dmem_resp  = (state == RESP);
  assign busy       = (state != IDLE);
endmodule

// File: tb/tb_dmem_responder.sv
// Randomized and directed bench for dmem_responder at LATENCY 2, 0 and 4,
// checked against a word-array reference model.

module tb_dmem_responder;
  localparam int NI = 3;
  localparam int LATS [NI] = '{2, 0, 4};

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] addr  [NI];
  logic [3:0]  rmask [NI];
  logic [3:0]  wmask [NI];
  logic [31:0] wdata [NI];
  logic [31:0] rdata [NI];
  logic        resp  [NI];
  logic        busy  [NI];
  logic [31:0] count [NI];

  logic [31:0] mdl   [NI][1024];
  int unsigned cnt_m [NI];
  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_LOG2(10), .LATENCY(2)) u_l2 (
    .clk(clk), .rst(rst), .dmem_addr(addr[0]), .dmem_rmask(rmask[0]),
    .dmem_wmask(wmask[0]), .dmem_wdata(wdata[0]), .dmem_rdata(rdata[0]),
    .dmem_resp(resp[0]), .busy(busy[0]), .req_count(count[0]));
  dmem_responder #(.DEPTH_LOG2(10), .LATENCY(0)) u_l0 (
    .clk(clk), .rst(rst), .dmem_addr(addr[1]), .dmem_rmask(rmask[1]),
    .dmem_wmask(wmask[1]), .dmem_wdata(wdata[1]), .dmem_rdata(rdata[1]),
    .dmem_resp(resp[1]), .busy(busy[1]), .req_count(count[1]));
  dmem_responder #(.DEPTH_LOG2(10), .LATENCY(4)) u_l4 (
    .clk(clk), .rst(rst), .dmem_addr(addr[2]), .dmem_rmask(rmask[2]),
    .dmem_wmask(wmask[2]), .dmem_wdata(wdata[2]), .dmem_rdata(rdata[2]),
    .dmem_resp(resp[2]), .busy(busy[2]), .req_count(count[2]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One transaction: masks held until the strobe, cleared at the following edge.
  task automatic do_req(input int k, input logic [31:0] a, input logic [3:0] rm,
                        input logic [3:0] wm, input logic [31:0] wd);
    int idx, lat;
    logic got;
    logic [31:0] exp_rd, w;
    idx    = int'(a[11:2]);
    exp_rd = (rm != 4'd0) ? mdl[k][idx] : 32'd0;
    addr[k] = a; rmask[k] = rm; wmask[k] = wm; wdata[k] = wd;
    chk($sformatf("busy_pre%0d", k), 32'(busy[k]), 32'd0);
    lat = 0; got = 1'b0;
    while (!got && lat < 40) begin
      tick();
      lat++;
      if (resp[k]) got = 1'b1;
    end
    chk($sformatf("latency%0d", k), lat, LATS[k] + 1);
    chk($sformatf("rdata%0d@%08h", k, a), rdata[k], exp_rd);
    chk($sformatf("busy_resp%0d", k), 32'(busy[k]), 32'd1);
    w = mdl[k][idx];
    for (int b = 0; b < 4; b++) if (wm[b]) w[8*b +: 8] = wd[8*b +: 8];
    mdl[k][idx] = w;
    cnt_m[k]++;
    tick();
    rmask[k] = 4'd0; wmask[k] = 4'd0;
    chk($sformatf("resp_one_cycle%0d", k), 32'(resp[k]), 32'd0);
    chk($sformatf("rdata_idle%0d", k), rdata[k], 32'd0);
    chk($sformatf("count%0d", k), count[k], cnt_m[k]);
  endtask

  initial begin
    int k, pulses;
    logic [31:0] a;
    logic [3:0] rm, wm;
    for (int i = 0; i < NI; i++) begin
      addr[i] = '0; rmask[i] = '0; wmask[i] = '0; wdata[i] = '0; cnt_m[i] = 0;
    end
    #1;
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("rst_resp%0d", i), 32'(resp[i]), 32'd0);
      chk($sformatf("rst_busy%0d", i), 32'(busy[i]), 32'd0);
      chk($sformatf("rst_rdata%0d", i), rdata[i], 32'd0);
      chk($sformatf("rst_count%0d", i), count[i], 32'd0);
    end
    tick(); tick();
    rst = 1'b1;
    tick();

    for (int i = 0; i < NI; i++)
      for (int j = 0; j < 16; j++) do_req(i, 32'(j * 4), 4'h0, 4'hF, $urandom);

    // Directed store/load, byte merge, aliasing, combined masks
    do_req(0, 32'h100, 4'h0, 4'hF, 32'hDEADBEEF);
    do_req(0, 32'h100, 4'hF, 4'h0, 32'h0);
    chk("store_load_word", mdl[0][64], 32'hDEADBEEF);
    do_req(0, 32'h102, 4'h0, 4'h4, 32'h00AA0000);
    do_req(0, 32'h100, 4'hF, 4'h0, 32'h0);
    chk("merge_model", mdl[0][64], 32'hDEAABEEF);
    do_req(0, 32'h0000_0010, 4'h0, 4'hF, 32'h11223344);
    do_req(0, 32'h0000_1010, 4'hF, 4'h0, 32'h0);
    do_req(0, 32'h20, 4'h0, 4'hF, 32'h12345678);
    do_req(0, 32'h20, 4'hF, 4'h1, 32'h000000FF);
    do_req(0, 32'h20, 4'hF, 4'h0, 32'h0);
    do_req(1, 32'h104, 4'h0, 4'hF, 32'hA5A5_0F0F);
    do_req(1, 32'h104, 4'hF, 4'h0, 32'h0);

    // Held load at LATENCY=0: strobes every second cycle
    addr[1] = 32'h104; rmask[1] = 4'hF;
    pulses = 0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      if (resp[1]) begin
        pulses++;
        chk("held_rdata", rdata[1], 32'hA5A5_0F0F);
      end
      if (i == 5) rmask[1] = 4'h0;
    end
    cnt_m[1] += 3;
    chk("held_pulses", pulses, 3);
    chk("held_count", count[1], cnt_m[1]);

    for (int n = 0; n < 60; n++) begin
      k  = $urandom_range(NI - 1, 0);
      a  = ($urandom & 32'hFFFF_F000) | (32'($urandom_range(15, 0)) << 2) | 32'($urandom_range(3, 0));
      rm = 4'($urandom_range(15, 0));
      wm = ($urandom_range(1, 0) == 1) ? 4'($urandom_range(15, 0)) : 4'h0;
      if (rm == 4'h0 && wm == 4'h0) rm = 4'hF;
      do_req(k, a, rm, wm, $urandom);
    end

    // Reset in WAIT drops the store and produces no response
    do_req(2, 32'h200, 4'h0, 4'hF, 32'h5555_5555);
    addr[2] = 32'h200; wmask[2] = 4'hF; wdata[2] = 32'hCAFEF00D;
    tick();
    wmask[2] = 4'h0;
    chk("wait_busy", 32'(busy[2]), 32'd1);
    tick();
    rst = 1'b0;
    #1;
    chk("rst_resp_now", 32'(resp[2]), 32'd0);
    chk("rst_busy_now", 32'(busy[2]), 32'd0);
    chk("rst_count_now", count[2], 32'd0);
    tick();
    rst = 1'b1;
    for (int i = 0; i < NI; i++) cnt_m[i] = 0;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (resp[2]) pulses++;
    end
    chk("no_resp_after_rst", pulses, 0);
    do_req(2, 32'h200, 4'hF, 4'h0, 32'h0);
    chk("count_other0", count[0], 32'd0);
    chk("count_other1", count[1], 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Responder end of the data-memory request/response interface driven by the core's memory unit.
- Accepts word-aligned load and store requests, each qualified by a byte read mask or byte write mask.
- Holds data in an internal word-addressed array and inserts a configurable number of wait states.
- Returns a single-cycle response strobe with read data.
- Serves as the data-side memory model for core-level simulation and as the base for the future data cache front end.

Parameters:
- DEPTH_LOG2, 10, log2 of the number of 32-bit words in the array; the word index is addr[DEPTH_LOG2+1:2].
- LATENCY, 2, wait-state cycles between request capture and the response strobe; legal range 0..15.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-low; asserting it (0) immediately forces the reset state.
- dmem_addr  input  32  request byte address; bits [1:0] ignored; bits above the word index ignored (aliasing).
- dmem_rmask  input  4  byte read mask; nonzero marks a load request.
- dmem_wmask  input  4  byte write mask; nonzero marks a store request.
- dmem_wdata  input  32  store data, already lane-aligned; byte i is written when wmask[i]=1.
- dmem_rdata  output  32  read word, valid only while dmem_resp=1 for a load.
- dmem_resp  output  1  one-cycle response strobe.
- busy  output  1  high from request capture through the response cycle inclusive.
- req_count  output  32  count of completed responses; wraps at 2^32.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; dmem_resp=0; dmem_rdata=0; busy=0; req_count=0; wait counter=0; captured request registers cleared. Array contents are not reset.
- FSM states are IDLE, WAIT and RESP.
- IDLE: a request is present when (dmem_rmask|dmem_wmask) != 0.
  - At the edge, capture addr, rmask, wmask and wdata; load the counter with LATENCY.
  - Go to WAIT if LATENCY > 0, otherwise to RESP.
  - busy rises the cycle after capture.
- WAIT: the counter decrements each cycle. When counter==1, the next state is RESP. Input changes during WAIT are ignored; only captured values are used.
- Entering RESP: the array access happens on the edge that enters RESP.
  - Load: dmem_rdata = the full stored word, no masking or shifting; the initiator extracts and extends bytes.
  - Store: the selected bytes are written; dmem_rdata = 0.
- RESP (exactly one cycle): dmem_resp=1; busy=1; req_count increments at the exiting edge; the next state is always IDLE.
  - No new capture is allowed in RESP, because the initiator's masks are still asserted that cycle and clear only at the following edge.
- Latency: a request first visible in IDLE in cycle N gives dmem_resp=1 in cycle N+1+LATENCY.
- Outside RESP, dmem_resp=0 and dmem_rdata=0.
- Both masks nonzero: treated as a store with wmask applied; dmem_rdata returns the pre-write word; counted once.
- Back-to-back requests: a request held or re-presented in the cycle after RESP is captured normally. The minimum spacing between response strobes is LATENCY+2 cycles.
- Read-after-write to the same word: the later load returns the merged post-write word.
- Misaligned address bits [1:0]: ignored for indexing. The masks are taken as given; no lane shifting is done here.
- Reset mid-operation: the in-flight request is dropped and no response is produced. A store in WAIT is not written; a store whose RESP edge has already passed remains written.
- Flush from the core is not a port: the initiator stops presenting masks, and an already-captured request still completes and responds.

Test Plan:
- LATENCY=2: store addr 0x100, wmask 0xF, wdata 0xDEADBEEF; then load addr 0x100, rmask 0xF -> each resp comes 3 cycles after the request appears; the load returns rdata 0xDEADBEEF; req_count=2.
- Byte merge: store 0xDEADBEEF at 0x100; store addr 0x102, wmask 0x4, wdata 0x00AA0000; load 0x100 -> rdata 0xDEADBEEF with byte 2 replaced, i.e. 0xDEAABEEF.
- LATENCY=0: load held with masks until resp, masks cleared after the strobe -> resp exactly 1 cycle after the request, resp lasts exactly one cycle, no duplicate capture, req_count increments by 1.
- Aliasing with DEPTH_LOG2=10: store 0x11223344 at 0x0000_0010; load 0x0000_1010 -> rdata 0x11223344.
- Simultaneous masks: rmask=0xF, wmask=0x1, wdata=0x000000FF on a word holding 0x12345678 -> rdata 0x12345678; the word becomes 0x123456FF.
- Reset mid-WAIT: LATENCY=4, store 0xCAFEF00D issued, rst=0 for one cycle two cycles after capture -> resp and busy drop immediately, no resp is ever produced, req_count=0, and a later load of that address does not return 0xCAFEF00D.
